// File: rtl/spi_parity_frame_checker.sv
// Purpose : assemble DATA_W-bit serial frames under chip-select, check trailing parity bit.
// Latency : outputs registered; strobe in cycle N is reflected in cycle N+1.
// Backpressure: none; every strobe is consumed, nothing stalls the serial source.
//
// Ports:
//   clk, reset (async active-low)
//   cs          chip select, 0 = frame active, 1 = idle/deselected
//   sample, in  one-cycle strobe qualifying the serial data bit
//   err_clr     synchronous clear of err_count
//   parity_bit  running expected parity for the frame in progress
//   data_out    last completed frame, MSB received first
//   frame_valid / parity_err / frame_abort  one-cycle status pulses
//   err_count   saturating parity-error count
//   bit_count   data bits received so far in the current frame
module spi_parity_frame_checker #(
  parameter int   DATA_W     = 8,
  parameter logic PARITY_ODD = 1'b1,
  parameter int   ERR_CNT_W  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cs,
  input  logic                         sample,
  input  logic                         in,
  input  logic                         err_clr,
  output logic                         parity_bit,
  output logic [DATA_W-1:0]            data_out,
  output logic                         frame_valid,
  output logic                         parity_err,
  output logic                         frame_abort,
  output logic [ERR_CNT_W-1:0]         err_count,
  output logic [$clog2(DATA_W+1)-1:0]  bit_count
);

  localparam int                   BC_W     = $clog2(DATA_W+1);
  localparam logic [BC_W-1:0]      BC_LAST  = BC_W'(DATA_W - 1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [ERR_CNT_W-1:0] CNT_ONE  = ERR_CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d;
  logic [DATA_W-1:0]      data_out_d;
  logic [BC_W-1:0]        bit_count_d;
  logic                   parity_bit_d;
  logic                   frame_valid_d;
  logic                   parity_err_d;
  logic                   frame_abort_d;
  logic [ERR_CNT_W-1:0]   err_count_d;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    data_out_d    = data_out;
    bit_count_d   = bit_count;
    parity_bit_d  = parity_bit;
    frame_valid_d = 1'b0;
    parity_err_d  = 1'b0;
    frame_abort_d = 1'b0;

    case (state_q)
      IDLE: begin
        // A strobe in the cs-falling cycle is not captured; the frame
        // starts on the first strobe once DATA is entered.
        if (!cs) begin
          state_d      = DATA;
          bit_count_d  = '0;
          parity_bit_d = PARITY_ODD;
        end
      end

      DATA: begin
        if (cs) begin
          // Deselect with no bits collected is a clean end of transfer.
          frame_abort_d = (bit_count != '0);
          state_d       = IDLE;
          bit_count_d   = '0;
          parity_bit_d  = PARITY_ODD;
        end else if (sample) begin
          shreg_d      = {shreg_q[DATA_W-2:0], in};
          bit_count_d  = bit_count + 1'b1;
          parity_bit_d = parity_bit ^ in;
          if (bit_count == BC_LAST) begin
            state_d = PARITY;
          end
        end
      end

      PARITY: begin
        if (cs) begin
          frame_abort_d = 1'b1;
          state_d       = IDLE;
          bit_count_d   = '0;
          parity_bit_d  = PARITY_ODD;
        end else if (sample) begin
          data_out_d    = shreg_q;
          frame_valid_d = 1'b1;
          parity_err_d  = (in != parity_bit);
          bit_count_d   = '0;
          parity_bit_d  = PARITY_ODD;
          // Stay selected: the next strobe is the first bit of a new frame.
          state_d       = DATA;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A clear coinciding with an error keeps that error counted.
    if (err_clr) begin
      err_count_d = parity_err_d ? CNT_ONE : '0;
    end else if (parity_err_d && (err_count != CNT_MAX)) begin
      err_count_d = err_count + 1'b1;
    end else begin
      err_count_d = err_count;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q     <= '0;
      data_out    <= '0;
      bit_count   <= '0;
      parity_bit  <= PARITY_ODD;
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      frame_abort <= 1'b0;
      err_count   <= '0;
    end else begin
      shreg_q     <= shreg_d;
      data_out    <= data_out_d;
      bit_count   <= bit_count_d;
      parity_bit  <= parity_bit_d;
      frame_valid <= frame_valid_d;
      parity_err  <= parity_err_d;
      frame_abort <= frame_abort_d;
      err_count   <= err_count_d;
    end
  end

endmodule
